// File: rtl/attn_pkg.sv
// Shared types and constants for the attention dot-product engine.
package attn_pkg;

  typedef enum logic [0:0] {
    LOAD_Q,
    ACCUM
  } attn_state_t;

  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefDim   = 4;
  localparam int unsigned DefOutW  = 8;
  localparam int unsigned DefShift = 0;

  // Full-precision sum of dim products of two data_w-bit unsigned values.
  function automatic int unsigned acc_width(input int unsigned data_w, input int unsigned dim);
    return 2 * data_w + $clog2(dim);
  endfunction

endpackage

// File: rtl/attn_score_narrow.sv
// Score narrowing: right-shift the full accumulator, then reduce to OUT_W bits.
// Build macro ATTN_SAT_EN selects saturation; without it the result wraps modulo 2^OUT_W.
module attn_score_narrow #(
  parameter int unsigned ACC_W = 18,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned SHIFT = 0
) (
  input  logic [ACC_W-1:0] res,
  output logic [OUT_W-1:0] score
);

  logic [ACC_W-1:0] t;

  assign t = res >> SHIFT;

  if (ACC_W > OUT_W) begin : g_reduce
`ifdef ATTN_SAT_EN
    // Any surviving bit above the output range clamps to full scale.
    assign score = (|t[ACC_W-1:OUT_W]) ? {OUT_W{1'b1}} : t[OUT_W-1:0];
`else
    logic unused_hi;
    assign unused_hi = ^t[ACC_W-1:OUT_W];
    assign score     = t[OUT_W-1:0];
`endif
  end else begin : g_extend
    assign score = OUT_W'(t);
  end

endmodule

// File: rtl/attn_dot_engine.sv
// Streaming query-key dot-product engine: loads a DIM-element query, then emits one
// narrowed score per DIM-element key on a valid/ready output. Optional saturation of the
// narrowed score is enabled by defining ATTN_SAT_EN (see attn_score_narrow).
module attn_dot_engine
  import attn_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned DIM    = DefDim,
  parameter int unsigned OUT_W  = DefOutW,
  parameter int unsigned SHIFT  = DefShift
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_vld,
  output logic              s_rdy,
  input  logic              s_last,
  output logic [OUT_W-1:0]  m_data,
  output logic              m_vld,
  input  logic              m_rdy,
  output logic              m_last
);

  localparam int unsigned ACC_W = acc_width(DATA_W, DIM);
  localparam int unsigned IDX_W = $clog2(DIM);
  localparam logic [IDX_W-1:0] IdxLast = IDX_W'(DIM - 1);

  attn_state_t state_q, state_d;

  logic [IDX_W-1:0]    idx_q;
  logic [DATA_W-1:0]   q_buf_q [DIM];
  logic [ACC_W-1:0]    acc_q;
  logic [OUT_W-1:0]    m_data_q;
  logic                m_vld_q;
  logic                m_last_q;

  logic                idx_last;
  logic                xfer;
  logic                score_fire;
  logic                pop;
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    res;
  logic [OUT_W-1:0]    score;

  assign idx_last   = (idx_q == IdxLast);
  assign xfer       = s_vld & s_rdy;
  assign pop        = m_vld_q & m_rdy;
  assign score_fire = xfer & idx_last & (state_q == ACCUM);
  assign prod       = (2*DATA_W)'(q_buf_q[idx_q]) * (2*DATA_W)'(s_data);
  assign res        = acc_q + ACC_W'(prod);

  assign m_data = m_data_q;
  assign m_vld  = m_vld_q;
  assign m_last = m_last_q;

  attn_score_narrow #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_narrow (
    .res   (res),
    .score (score)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= LOAD_Q;
    else        state_q <= state_d;
  end

  // Next state: leave a phase only when its final element is accepted.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      LOAD_Q: if (xfer && idx_last)           state_d = ACCUM;
      ACCUM:  if (xfer && idx_last && s_last) state_d = LOAD_Q;
    endcase
  end

  // Input ready: only a key's final element waits on an undelivered score.
  always_comb begin
    s_rdy = 1'b1;
    unique case (state_q)
      LOAD_Q: s_rdy = 1'b1;
      ACCUM:  s_rdy = !(idx_last && m_vld_q && !m_rdy);
    endcase
  end

  // Query buffer, element index, accumulator and output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q    <= '0;
      acc_q    <= '0;
      m_data_q <= '0;
      m_vld_q  <= 1'b0;
      m_last_q <= 1'b0;
      for (int i = 0; i < DIM; i++) q_buf_q[i] <= '0;
    end else begin
      if (xfer) begin
        idx_q <= idx_last ? '0 : idx_q + IDX_W'(1);
        if (state_q == LOAD_Q) q_buf_q[idx_q] <= s_data;
        else                   acc_q <= idx_last ? '0 : res;
      end
      // A new score wins over a pop so back-to-back scores leave no bubble.
      if (score_fire) begin
        m_data_q <= score;
        m_vld_q  <= 1'b1;
        m_last_q <= s_last;
      end else if (pop) begin
        m_vld_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_attn_dot_engine.sv
// Self-checking bench for attn_dot_engine: directed cases plus randomized traffic,
// compared every cycle against a behavioural model of the engine.
module tb_attn_dot_engine;

  localparam int DIM   = 4;
  localparam int OUT_W = 8;
  localparam int SH2   = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s_data = '0;
  logic       s_vld = 1'b0;
  logic       s_last = 1'b0;
  logic       m_rdy = 1'b1;
  logic       s_rdy, m_vld, m_last;
  logic [7:0] m_data;
  logic       s_rdy_sh, m_vld_sh, m_last_sh;
  logic [7:0] m_data_sh;

  always #5 clk = ~clk;

  attn_dot_engine #(.DATA_W(8), .DIM(DIM), .OUT_W(OUT_W), .SHIFT(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_vld(s_vld), .s_rdy(s_rdy),
    .s_last(s_last), .m_data(m_data), .m_vld(m_vld), .m_rdy(m_rdy), .m_last(m_last)
  );

  attn_dot_engine #(.DATA_W(8), .DIM(DIM), .OUT_W(OUT_W), .SHIFT(SH2)) u_dut_sh (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_vld(s_vld), .s_rdy(s_rdy_sh),
    .s_last(s_last), .m_data(m_data_sh), .m_vld(m_vld_sh), .m_rdy(m_rdy), .m_last(m_last_sh)
  );

  int total = 0;
  int bad   = 0;
  bit rnd_rdy = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint narrow(input longint res, input int sh);
    longint t;
    t = res >> sh;
`ifdef ATTN_SAT_EN
    if (t > ((64'sd1 << OUT_W) - 1)) return (64'sd1 << OUT_W) - 1;
`endif
    return t & ((64'sd1 << OUT_W) - 1);
  endfunction

  // Model state: what the engine's outputs must be after the upcoming clock edge.
  bit     started = 1'b0;
  bit     mode_key;   // 0: collecting the query, 1: scoring keys
  int     pos;        // element position within the current vector
  longint qv [DIM];
  longint acc;
  bit     exp_vld, exp_last;
  longint exp_data, exp_data_sh;

  // Compare DUT against the model, then advance the model by the coming edge.
  always @(negedge clk) begin
    bit     exp_srdy, xfer, fire, new_last;
    longint sum;
    exp_srdy = !mode_key || !(pos == DIM - 1 && exp_vld && !m_rdy);
    if (started) begin
      chk("s_rdy", s_rdy, exp_srdy);
      chk("s_rdy_sh", s_rdy_sh, exp_srdy);
      chk("m_vld", m_vld, exp_vld);
      chk("m_vld_sh", m_vld_sh, exp_vld);
      if (exp_vld) begin
        chk("m_data", m_data, exp_data);
        chk("m_last", m_last, exp_last);
        chk("m_data_sh", m_data_sh, exp_data_sh);
        chk("m_last_sh", m_last_sh, exp_last);
      end
    end
    if (!rst_n) begin
      started  = 1'b1;
      mode_key = 1'b0;
      pos      = 0;
      acc      = 0;
      exp_vld  = 1'b0;
      exp_last = 1'b0;
      exp_data = 0;
      exp_data_sh = 0;
      foreach (qv[i]) qv[i] = 0;
    end else if (started) begin
      xfer = s_vld && exp_srdy;
      fire = 1'b0;
      new_last = 1'b0;
      sum = 0;
      if (xfer) begin
        if (!mode_key) begin
          qv[pos] = s_data;
          if (pos == DIM - 1) begin pos = 0; mode_key = 1'b1; end
          else pos++;
        end else begin
          acc += qv[pos] * longint'(s_data);
          if (pos == DIM - 1) begin
            fire = 1'b1;
            sum = acc;
            new_last = s_last;
            acc = 0;
            pos = 0;
            if (s_last) mode_key = 1'b0;
          end else pos++;
        end
      end
      if (fire) begin
        exp_vld = 1'b1;
        exp_data = narrow(sum, 0);
        exp_data_sh = narrow(sum, SH2);
        exp_last = new_last;
      end else if (exp_vld && m_rdy) begin
        exp_vld = 1'b0;
      end
    end
  end

  // Present one element and hold it until accepted (bounded).
  task automatic send(input int d, input bit last);
    bit done;
    done = 1'b0;
    s_vld = 1'b1;
    s_data = 8'(d);
    s_last = last;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (s_rdy) done = 1'b1;
      @(posedge clk);
      #1;
      if (rnd_rdy) m_rdy = 1'($urandom_range(0, 1));
    end
    s_vld = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL send_timeout: element %0d not accepted within 64 cycles", d);
    end
  endtask

  task automatic send_vec(input int a, input int b, input int c, input int d, input bit last);
    send(a, 1'b0);
    send(b, 1'b0);
    send(c, 1'b0);
    send(d, last);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("reset_m_vld", m_vld, 0);
    chk("reset_m_data", m_data, 0);
    chk("reset_m_last", m_last, 0);
    chk("reset_s_rdy", s_rdy, 1);

    // Basic score, and return to query loading afterwards.
    send_vec(1, 2, 3, 4, 1'b0);
    send_vec(1, 1, 1, 1, 1'b1);
    #1;
    chk("t1_m_data", m_data, 10);
    chk("t1_model", exp_data, 10);
    chk("t1_m_last", m_last, 1);
    chk("t1_m_vld", m_vld, 1);

    // Largest product sum: wrap vs saturate, and the shifted instance.
    send_vec(255, 255, 255, 255, 1'b1);
    send_vec(255, 255, 255, 255, 1'b1);
    #1;
`ifdef ATTN_SAT_EN
    chk("t2_m_data_sat", m_data, 255);
`else
    chk("t2_m_data_wrap", m_data, 4);
`endif
    chk("t3_m_data_shift", m_data_sh, 254);
    chk("t3_model", exp_data_sh, 254);

    // Back-pressure: first score held, second key's final element stalls.
    @(posedge clk);
    #1 m_rdy = 1'b0;
    send_vec(1, 2, 3, 4, 1'b0);
    send_vec(1, 0, 0, 0, 1'b0);
    send(0, 1'b0);
    send(0, 1'b0);
    send(0, 1'b0);
    s_vld = 1'b1;
    s_data = 8'd1;
    s_last = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    chk("t4_stall_s_rdy", s_rdy, 0);
    chk("t4_held_m_vld", m_vld, 1);
    chk("t4_held_m_data", m_data, 1);
    chk("t4_held_m_last", m_last, 0);
    @(posedge clk);
    #1 m_rdy = 1'b1;
    send(1, 1'b1);
    #1;
    chk("t5_nobubble_m_vld", m_vld, 1);
    chk("t5_second_m_data", m_data, 4);
    chk("t5_second_m_last", m_last, 1);
    @(posedge clk);
    #2;
    chk("t5_drained_m_vld", m_vld, 0);

    // Reset mid-key with a score pending.
    send_vec(3, 3, 3, 3, 1'b0);
    m_rdy = 1'b0;
    send_vec(1, 1, 1, 1, 1'b0);
    send(5, 1'b0);
    send(5, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    m_rdy = 1'b1;
    #1;
    chk("t6_reset_m_vld", m_vld, 0);
    chk("t6_reset_s_rdy", s_rdy, 1);
    send_vec(2, 0, 0, 0, 1'b0);
    send_vec(7, 9, 9, 9, 1'b1);
    #1;
    chk("t6_m_data", m_data, 14);
    chk("t6_model", exp_data, 14);

    // Randomized traffic with random back-pressure and idle gaps.
    rnd_rdy = 1'b1;
    for (int v = 0; v < 150; v++) begin
      int nkeys;
      nkeys = $urandom_range(1, 3);
      for (int e = 0; e < DIM; e++) begin
        send(($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 255),
             1'($urandom_range(0, 1)));
        if ($urandom_range(0, 4) == 0) begin
          @(posedge clk);
          #1;
        end
      end
      for (int k = 0; k < nkeys; k++) begin
        for (int e = 0; e < DIM; e++) begin
          send(($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 255),
               (e == DIM - 1) ? (k == nkeys - 1) : 1'($urandom_range(0, 1)));
          if ($urandom_range(0, 4) == 0) begin
            @(posedge clk);
            #1;
          end
        end
      end
    end
    rnd_rdy = 1'b0;
    m_rdy = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    chk("final_drained", m_vld, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
